// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an I-cache (c0) and a D-cache (c1), one transaction in flight.
// Build option MEM_ARBITER_RR_EN selects round-robin arbitration; without it c1 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          c0_rw_flag,
  input  logic [ADDR_W-1:0]   c0_addr,
  input  logic [DATA_W-1:0]   c0_write_data,
  input  logic [DATA_W/8-1:0] c0_write_mask,
  output logic [DATA_W-1:0]   c0_read_data,
  output logic                c0_busy,
  output logic                c0_done,
  input  logic [1:0]          c1_rw_flag,
  input  logic [ADDR_W-1:0]   c1_addr,
  input  logic [DATA_W-1:0]   c1_write_data,
  input  logic [DATA_W/8-1:0] c1_write_mask,
  output logic [DATA_W-1:0]   c1_read_data,
  output logic                c1_busy,
  output logic                c1_done,
  output logic [1:0]          mem_rw_flag,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic [DATA_W/8-1:0] mem_write_mask,
  input  logic [DATA_W-1:0]   mem_read_data,
  input  logic                mem_busy,
  input  logic                mem_done
);

  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic              winner_reg;
  logic [1:0]        rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [MASK_W-1:0] mask_reg;

  // Requester ports gathered into arrays so per-requester logic is generated once.
  logic [1:0]        req_flag  [2];
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [MASK_W-1:0] req_mask  [2];
  logic [1:0]        req_valid;
  logic [1:0]        req_busy;
  logic [1:0]        req_done;

  logic grant_id;
  logic accept;
  logic in_busy;
  logic capture;

  assign req_flag[0]  = c0_rw_flag;
  assign req_flag[1]  = c1_rw_flag;
  assign req_addr[0]  = c0_addr;
  assign req_addr[1]  = c1_addr;
  assign req_wdata[0] = c0_write_data;
  assign req_wdata[1] = c1_write_data;
  assign req_mask[0]  = c0_write_mask;
  assign req_mask[1]  = c1_write_mask;

  assign in_busy = (state_reg == ST_BUSY);
  assign accept  = (state_reg == ST_IDLE) && !mem_busy && (req_valid != 2'b00);
  assign capture = in_busy && mem_done && (rw_reg == RW_READ);

`ifdef MEM_ARBITER_RR_EN
  // Pointer remembers the last granted requester; on a tie the other one wins.
  logic rr_ptr_reg;

  always_comb begin
    if (req_valid == 2'b11) begin
      grant_id = ~rr_ptr_reg;
    end else begin
      grant_id = req_valid[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= 1'b0;
    end else if (accept) begin
      rr_ptr_reg <= grant_id;
    end
  end
`else
  assign grant_id = req_valid[1];
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: if (mem_done) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The request is captured once at grant; the requester may change its ports afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_reg <= 1'b0;
      rw_reg     <= RW_IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      mask_reg   <= '0;
    end else if (accept) begin
      winner_reg <= grant_id;
      rw_reg     <= req_flag[grant_id];
      addr_reg   <= req_addr[grant_id];
      wdata_reg  <= req_wdata[grant_id];
      mask_reg   <= req_mask[grant_id];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic [DATA_W-1:0] rdata_reg;

      assign req_valid[gi] = (req_flag[gi] == RW_READ) || (req_flag[gi] == RW_WRITE);
      assign req_busy[gi]  = (state_reg != ST_IDLE) && (winner_reg == 1'(gi));
      assign req_done[gi]  = (state_reg == ST_RESP) && (winner_reg == 1'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata_reg <= '0;
        end else if (capture && (winner_reg == 1'(gi))) begin
          rdata_reg <= mem_read_data;
        end
      end
    end
  endgenerate

  assign c0_read_data = g_req[0].rdata_reg;
  assign c1_read_data = g_req[1].rdata_reg;
  assign c0_busy      = req_busy[0];
  assign c1_busy      = req_busy[1];
  assign c0_done      = req_done[0];
  assign c1_done      = req_done[1];

  // The shared port is quiet outside BUSY so the memory never sees a stale request.
  assign mem_rw_flag    = in_busy ? rw_reg    : RW_IDLE;
  assign mem_addr       = in_busy ? addr_reg  : '0;
  assign mem_write_data = in_busy ? wdata_reg : '0;
  assign mem_write_mask = in_busy ? mask_reg  : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    flag  [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [MW-1:0] wmask [2];
  logic [DW-1:0] c0_read_data, c1_read_data;
  logic          c0_busy, c1_busy, c0_done, c1_done;
  logic [1:0]    mem_rw_flag;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic [MW-1:0] mem_write_mask;
  logic [DW-1:0] mem_read_data;
  logic          mem_busy, mem_done;

  int checks = 0;
  int failures = 0;

  // Model state: last read value delivered to each requester and last granted id.
  logic [DW-1:0] exp_rd [2];
  logic          last_grant;

  logic [1:0]    busy_v, done_v;
  logic [DW-1:0] rd [2];
  logic [69:0]   mem_bus;
  logic [137:0]  all_out;

  assign busy_v  = {c1_busy, c0_busy};
  assign done_v  = {c1_done, c0_done};
  assign rd[0]   = c0_read_data;
  assign rd[1]   = c1_read_data;
  assign mem_bus = {mem_rw_flag, mem_addr, mem_write_data, mem_write_mask};
  assign all_out = {c0_read_data, c1_read_data, busy_v, done_v, mem_bus};

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .c0_rw_flag(flag[0]), .c0_addr(addr[0]), .c0_write_data(wdata[0]), .c0_write_mask(wmask[0]),
    .c0_read_data(c0_read_data), .c0_busy(c0_busy), .c0_done(c0_done),
    .c1_rw_flag(flag[1]), .c1_addr(addr[1]), .c1_write_data(wdata[1]), .c1_write_mask(wmask[1]),
    .c1_read_data(c1_read_data), .c1_busy(c1_busy), .c1_done(c1_done),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_read_data(mem_read_data),
    .mem_busy(mem_busy), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  function automatic logic is_req(input logic [1:0] f);
    return (f == 2'b01) || (f == 2'b10);
  endfunction

  // Arbitration rule: a lone requester wins; on a tie c1 wins, or the non-last one under round-robin.
  function automatic logic pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef MEM_ARBITER_RR_EN
      return ~last_grant;
`else
      return 1'b1;
`endif
    end
    return v1;
  endfunction

  function automatic logic [1:0] onehot(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    mem_busy = 1'b0;
    mem_done = 1'b0;
    mem_read_data = '0;
    for (int i = 0; i < 2; i++) begin
      flag[i] = 2'b00; addr[i] = '0; wdata[i] = '0; wmask[i] = '0;
      exp_rd[i] = '0;
    end
    last_grant = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_release_idle got=%h exp=0", all_out);
    end
  endtask

  task automatic test_single_read();
    flag[0] = 2'b01; addr[0] = 32'h100; wdata[0] = '0; wmask[0] = '0;
    @(negedge clk);
    last_grant = 1'b0;
    checks++;
    if (mem_bus !== {2'b01, 32'h100, 32'h0, 4'h0} || busy_v !== 2'b01 || done_v !== 2'b00) begin
      failures++; $display("FAIL read_busy1 got=%h/%b/%b exp=%h/01/00", mem_bus, busy_v, done_v, {2'b01, 32'h100, 36'h0});
    end
    @(negedge clk);
    checks++;
    if (mem_bus !== {2'b01, 32'h100, 32'h0, 4'h0} || done_v !== 2'b00) begin
      failures++; $display("FAIL read_busy2 got=%h/%b", mem_bus, done_v);
    end
    mem_done = 1'b1; mem_read_data = 32'hDEADBEEF;
    @(negedge clk);
    exp_rd[0] = 32'hDEADBEEF;
    checks++;
    if (done_v !== 2'b01 || busy_v !== 2'b01 || rd[0] !== exp_rd[0] || mem_rw_flag !== 2'b00) begin
      failures++; $display("FAIL read_done got=%b/%b/%h/%b exp=01/01/%h/00", done_v, busy_v, rd[0], mem_rw_flag, exp_rd[0]);
    end
    mem_done = 1'b0; mem_read_data = '0; flag[0] = 2'b00;
    @(negedge clk);
    checks++;
    if (busy_v !== 2'b00 || done_v !== 2'b00 || rd[0] !== exp_rd[0]) begin
      failures++; $display("FAIL read_after got=%b/%b/%h exp=00/00/%h", busy_v, done_v, rd[0], exp_rd[0]);
    end
  endtask

  task automatic test_write();
    logic [69:0] exp_bus;
    flag[1] = 2'b10; addr[1] = 32'h2000; wdata[1] = 32'h12345678; wmask[1] = 4'b0011;
    exp_bus = {2'b10, 32'h2000, 32'h12345678, 4'b0011};
    @(negedge clk);
    last_grant = 1'b1;
    // Scramble the requester's ports; the arbiter must keep driving its captured copy.
    addr[1] = 32'hFFFF0000; wdata[1] = 32'h0BADF00D; wmask[1] = 4'b1100;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mem_bus !== exp_bus || busy_v !== 2'b10 || done_v !== 2'b00) begin
        failures++; $display("FAIL write_busy%0d got=%h/%b exp=%h/10", k, mem_bus, busy_v, exp_bus);
      end
      @(negedge clk);
    end
    checks++;
    if (mem_bus !== exp_bus) begin
      failures++; $display("FAIL write_busy_hold got=%h exp=%h", mem_bus, exp_bus);
    end
    mem_done = 1'b1; mem_read_data = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (done_v !== 2'b10 || rd[1] !== exp_rd[1] || rd[0] !== exp_rd[0] || mem_rw_flag !== 2'b00) begin
      failures++; $display("FAIL write_done got=%b/%h/%h exp=10/%h/%h", done_v, rd[1], rd[0], exp_rd[1], exp_rd[0]);
    end
    mem_done = 1'b0; mem_read_data = '0; flag[1] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_priority();
    logic w;
    logic [DW-1:0] rv;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (!is_req(flag[i])) begin
          flag[i] = 2'b01; addr[i] = $urandom; wdata[i] = $urandom; wmask[i] = 4'($urandom);
        end
      end
      w = pick(is_req(flag[0]), is_req(flag[1]));
      @(negedge clk);
      last_grant = w;
      checks++;
      if (busy_v !== onehot(w) || mem_bus !== {flag[w], addr[w], wdata[w], wmask[w]}) begin
        failures++; $display("FAIL prio_grant round=%0d got=%b/%h exp=%b/%h", r, busy_v, mem_bus, onehot(w), {flag[w], addr[w], wdata[w], wmask[w]});
      end
      rv = $urandom;
      mem_done = 1'b1; mem_read_data = rv;
      @(negedge clk);
      exp_rd[w] = rv;
      checks++;
      if (done_v !== onehot(w) || rd[0] !== exp_rd[0] || rd[1] !== exp_rd[1]) begin
        failures++; $display("FAIL prio_done round=%0d got=%b/%h/%h exp=%b/%h/%h", r, done_v, rd[0], rd[1], onehot(w), exp_rd[0], exp_rd[1]);
      end
      mem_done = 1'b0; mem_read_data = '0; flag[w] = 2'b00;
      @(negedge clk);
      checks++;
      if (busy_v !== 2'b00 || mem_rw_flag !== 2'b00) begin
        failures++; $display("FAIL prio_no_regrant round=%0d got=%b/%b exp=00/00", r, busy_v, mem_rw_flag);
      end
    end
    flag[0] = 2'b00; flag[1] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_mem_busy();
    logic [DW-1:0] rv;
    flag[0] = 2'b01; addr[0] = $urandom; wdata[0] = $urandom; wmask[0] = 4'($urandom);
    mem_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_rw_flag, busy_v, done_v} !== 6'b0) begin
        failures++; $display("FAIL membusy_hold cycle=%0d got=%b exp=0", k, {mem_rw_flag, busy_v, done_v});
      end
    end
    mem_busy = 1'b0;
    @(negedge clk);
    last_grant = 1'b0;
    checks++;
    if (busy_v !== 2'b01 || mem_bus !== {2'b01, addr[0], wdata[0], wmask[0]}) begin
      failures++; $display("FAIL membusy_grant got=%b/%h exp=01/%h", busy_v, mem_bus, {2'b01, addr[0], wdata[0], wmask[0]});
    end
    rv = $urandom;
    mem_done = 1'b1; mem_read_data = rv;
    @(negedge clk);
    exp_rd[0] = rv;
    checks++;
    if (done_v !== 2'b01 || rd[0] !== exp_rd[0]) begin
      failures++; $display("FAIL membusy_done got=%b/%h exp=01/%h", done_v, rd[0], exp_rd[0]);
    end
    mem_done = 1'b0; mem_read_data = '0; flag[0] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rv;
    flag[0] = 2'b01; addr[0] = $urandom; wdata[0] = $urandom; wmask[0] = 4'($urandom);
    @(negedge clk);
    checks++;
    if (busy_v !== 2'b01) begin
      failures++; $display("FAIL rstmid_busy got=%b exp=01", busy_v);
    end
    #2 rst = 1'b0;
    #1;
    exp_rd[0] = '0; exp_rd[1] = '0; last_grant = 1'b0;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL rstmid_async got=%h exp=0", all_out);
    end
    mem_done = 1'b1; mem_read_data = $urandom;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL rstmid_held got=%h exp=0", all_out);
    end
    mem_done = 1'b0; mem_read_data = '0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_v !== 2'b01 || mem_bus !== {2'b01, addr[0], wdata[0], wmask[0]}) begin
      failures++; $display("FAIL rstmid_regrant got=%b/%h exp=01/%h", busy_v, mem_bus, {2'b01, addr[0], wdata[0], wmask[0]});
    end
    rv = $urandom;
    mem_done = 1'b1; mem_read_data = rv;
    @(negedge clk);
    exp_rd[0] = rv;
    checks++;
    if (done_v !== 2'b01 || rd[0] !== exp_rd[0] || rd[1] !== exp_rd[1]) begin
      failures++; $display("FAIL rstmid_done got=%b/%h/%h exp=01/%h/%h", done_v, rd[0], rd[1], exp_rd[0], exp_rd[1]);
    end
    mem_done = 1'b0; mem_read_data = '0; flag[0] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic          w;
    logic [69:0]   exp_bus;
    logic [1:0]    ef;
    logic [DW-1:0] rv;
    int            nb, d;
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!is_req(flag[i])) begin
          case ($urandom_range(0, 3))
            0: flag[i] = 2'b01;
            1: flag[i] = 2'b10;
            2: flag[i] = 2'b00;
            default: flag[i] = 2'b11;
          endcase
          addr[i] = $urandom; wdata[i] = $urandom; wmask[i] = 4'($urandom);
        end
      end
      nb = $urandom_range(0, 2);
      if (nb > 0) begin
        mem_busy = 1'b1;
        for (int k = 0; k < nb; k++) begin
          @(negedge clk);
          checks++;
          if ({mem_rw_flag, busy_v, done_v} !== 6'b0) begin
            failures++; $display("FAIL rand_membusy it=%0d got=%b exp=0", it, {mem_rw_flag, busy_v, done_v});
          end
        end
        mem_busy = 1'b0;
      end
      if (!is_req(flag[0]) && !is_req(flag[1])) begin
        @(negedge clk);
        checks++;
        if ({mem_rw_flag, busy_v, done_v} !== 6'b0) begin
          failures++; $display("FAIL rand_idle it=%0d flags=%b/%b got=%b exp=0", it, flag[0], flag[1], {mem_rw_flag, busy_v, done_v});
        end
        continue;
      end
      w = pick(is_req(flag[0]), is_req(flag[1]));
      ef = flag[w];
      exp_bus = {flag[w], addr[w], wdata[w], wmask[w]};
      @(negedge clk);
      last_grant = w;
      checks++;
      if (busy_v !== onehot(w) || done_v !== 2'b00 || mem_bus !== exp_bus) begin
        failures++; $display("FAIL rand_grant it=%0d got=%b/%h exp=%b/%h", it, busy_v, mem_bus, onehot(w), exp_bus);
      end
      addr[w] = $urandom; wdata[w] = $urandom; wmask[w] = 4'($urandom);
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        checks++;
        if (busy_v !== onehot(w) || done_v !== 2'b00 || mem_bus !== exp_bus) begin
          failures++; $display("FAIL rand_hold it=%0d got=%b/%b/%h exp=%b/00/%h", it, busy_v, done_v, mem_bus, onehot(w), exp_bus);
        end
      end
      rv = $urandom;
      mem_done = 1'b1; mem_read_data = rv;
      @(negedge clk);
      if (ef == 2'b01) exp_rd[w] = rv;
      checks++;
      if (done_v !== onehot(w) || busy_v !== onehot(w) || rd[0] !== exp_rd[0] || rd[1] !== exp_rd[1] || mem_rw_flag !== 2'b00) begin
        failures++; $display("FAIL rand_done it=%0d got=%b/%b/%h/%h exp=%b/%b/%h/%h", it, done_v, busy_v, rd[0], rd[1], onehot(w), onehot(w), exp_rd[0], exp_rd[1]);
      end
      mem_done = 1'b0; mem_read_data = '0; flag[w] = 2'b00;
      @(negedge clk);
      checks++;
      if ({mem_rw_flag, busy_v, done_v} !== 6'b0) begin
        failures++; $display("FAIL rand_after it=%0d got=%b exp=0", it, {mem_rw_flag, busy_v, done_v});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_priority();
    test_mem_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; mask width is DATA_W/8.
REQ-003 Port clk, input, 1, single clock; all logic rising-edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Ports c0_rw_flag / c1_rw_flag, input, 2 each, requester 0 (I-cache) / requester 1 (D-cache) request: 00 idle, 01 read, 10 write, 11 illegal (treated as idle).
REQ-006 Ports c0_addr / c1_addr, input, ADDR_W each, request address.
REQ-007 Ports c0_write_data / c1_write_data, input, DATA_W each, write data.
REQ-008 Ports c0_write_mask / c1_write_mask, input, DATA_W/8 each, byte-enable mask.
REQ-009 Ports c0_read_data / c1_read_data, output, DATA_W each, registered read result.
REQ-010 Ports c0_busy / c1_busy, output, 1 each, high while that requester has an accepted, uncompleted transaction.
REQ-011 Ports c0_done / c1_done, output, 1 each, one-cycle completion pulse.
REQ-012 Ports mem_rw_flag (output, 2), mem_addr (output, ADDR_W), mem_write_data (output, DATA_W), mem_write_mask (output, DATA_W/8): shared memory request.
REQ-013 Ports mem_read_data (input, DATA_W), mem_busy (input, 1), mem_done (input, 1): shared memory response.

Function
REQ-014 FSM states IDLE, BUSY, RESP; encoding free; exactly one transaction in flight.
REQ-015 IDLE: when mem_busy=0 and at least one valid request exists, SHALL latch winner id, rw_flag, addr, write_data, mask, and go to BUSY next edge.
REQ-016 IDLE with mem_busy=1, or with no valid request: SHALL stay in IDLE and latch nothing.
REQ-017 BUSY: mem_rw_flag/addr/write_data/write_mask SHALL be driven from latched values and held constant until mem_done=1.
REQ-018 In every state other than BUSY, mem_rw_flag SHALL be 00; mem_addr/data/mask SHALL be 0.
REQ-019 BUSY with mem_done=1: SHALL capture mem_read_data into the winner's read_data register (reads only) and go to RESP.
REQ-020 RESP: winner's done SHALL be 1 for exactly one cycle; next state IDLE unconditionally.
REQ-021 Requester SHALL deassert rw_flag on the edge ending its done cycle; the arbiter ignores requests in RESP, so no back-to-back re-grant from stale flags.
REQ-022 cN_busy SHALL be 1 from the edge entering BUSY for requester N through the RESP cycle; a requesting but unserved client sees busy=0.
REQ-023 Minimum latency, request to done: 3 cycles with mem_done in the first BUSY cycle.
REQ-024 cN_read_data SHALL hold its value until the next completed read for that requester; writes leave it unchanged.
REQ-025 Fixed priority (REQ-031 without macro): simultaneous requests grant requester 1.
REQ-026 A request arriving while the other requester is in BUSY/RESP SHALL wait, unlatched, until IDLE.
REQ-027 Missing mem_done keeps the FSM in BUSY indefinitely; no timeout.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, all outputs 0, all latched request fields 0, round-robin pointer 0.
REQ-029 Reset mid-transaction SHALL abort it with no done pulse; after release the FSM restarts from IDLE.
REQ-030 First grant after reset is evaluated on the first rising edge with rst=1.

Configuration
REQ-031 Macro MEM_ARBITER_RR_EN defined: round-robin; 1-bit pointer holds last-granted id and updates on entering BUSY; on simultaneous requests the requester not equal to the pointer wins. Undefined: fixed priority per REQ-025, no pointer register.

Verification
REQ-032 Single read: c0_rw_flag=01, c0_addr=0x100, mem_done one cycle after BUSY with mem_read_data=0xDEADBEEF -> mem_addr=0x100, mem_rw_flag=01, c0_done pulse, c0_read_data=0xDEADBEEF, total 4 cycles.
REQ-033 Write: c1_rw_flag=10, addr=0x2000, data=0x12345678, mask=0011 -> mem outputs match exactly for the whole BUSY period, c1_done pulse, c1_read_data unchanged.
REQ-034 Simultaneous reads from both, 4 rounds: without macro all grants to c1 while c1 re-requests; with MEM_ARBITER_RR_EN grants alternate c1,c0,c1,c0.
REQ-035 mem_busy=1 held 5 cycles with c0 requesting -> mem_rw_flag stays 00, FSM in IDLE; grant one edge after mem_busy falls.
REQ-036 rst pulled low in BUSY -> all outputs 0 immediately, no done; after release a new c0 read completes normally.
